// File: rtl/wb_result_select.sv
// Writeback result select: picks the ALU result or (optionally byte-extended) load
// data and queues it for the register-file write port. A small skid FIFO plus a
// registered output stage absorb write-port stalls without dropping results, and
// writes leave in the order they were accepted.
module wb_result_select #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_to_reg,
  input  logic              load_byte,
  input  logic              load_unsigned,
  input  logic              byte_sel,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pending
);

  localparam int HALF  = DATA_W / 2;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // FIFO storage; validity is tracked by count_reg, so the array needs no reset.
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_waddr_reg;
  logic [DATA_W-1:0] rf_wdata_reg;

  logic [DATA_W-1:0] sel_data;
  logic [HALF-1:0]   byte_val;
  logic              drop_zero;
  logic              push;
  logic              pop;

  // Ready depends only on the registered count so it never loops through in_valid/rf_ready.
  assign in_ready  = (count_reg < DEPTH_C);
  assign drop_zero = (ZERO_REG != 0) && (rd_addr == '0);
  assign push      = in_valid && in_ready && reg_write && !drop_zero;
  // Pop whenever the output stage is empty or its current write completes this cycle.
  assign pop       = (count_reg != '0) && (!rf_we_reg || rf_ready);

  // Select the final write data at accept time so the FIFO holds ready-to-write values.
  always_comb begin
    byte_val = byte_sel ? mem_data[DATA_W-1:HALF] : mem_data[HALF-1:0];
    sel_data = alu_result;
    if (mem_to_reg) begin
      if (!load_byte) begin
        sel_data = mem_data;
      end else if (load_unsigned) begin
        sel_data = {{HALF{1'b0}}, byte_val};
      end else begin
        sel_data = {{HALF{byte_val[HALF-1]}}, byte_val};
      end
    end
  end

  // Write accepted results into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= sel_data;
      addr_mem[wr_ptr_reg] <= rd_addr;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + ONE_C;
        2'b01:   count_reg <= count_reg - ONE_C;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Output stage: load the FIFO head on pop, hold while stalled, clear once the write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else if (pop) begin
      rf_we_reg    <= 1'b1;
      rf_waddr_reg <= addr_mem[rd_ptr_reg];
      rf_wdata_reg <= data_mem[rd_ptr_reg];
    end else if (rf_we_reg && rf_ready) begin
      rf_we_reg    <= 1'b0;
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign pending  = (count_reg != '0) || rf_we_reg;

endmodule
